// File: rtl/hazard_forward_unit.sv
// Forwarding / load-use stall controller: tracks destination registers of the
// NSTAGES in-flight instructions and picks the youngest producer per decode operand.
module hazard_forward_unit #(
   parameter int NSTAGES    = 2,
   parameter int LOAD_READY = 2,
   parameter int REG_W      = 5,
   parameter int SW         = $clog2(NSTAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [REG_W-1:0] issue_rs,
   input  logic [REG_W-1:0] issue_rt,
   input  logic [REG_W-1:0] issue_wr,
   input  logic             issue_regwrite,
   input  logic             issue_memread,
   input  logic             flush,
   output logic             stall,
   output logic [SW-1:0]    fwd_sel_a,
   output logic [SW-1:0]    fwd_sel_b,
   output logic [3:0]       pending_writes
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] wr;
      logic             regwrite;
      logic             memread;
   } entry_t;

   // stage[k] holds the instruction issued k advancing cycles ago
   entry_t stage [1:NSTAGES];

   logic          issue_go;
   logic [SW-1:0] sel_a;
   logic [SW-1:0] sel_b;
   logic          load_a;
   logic          load_b;

   function automatic logic match(entry_t e, logic [REG_W-1:0] r);
      return e.valid && e.regwrite && (e.wr == r) && (r != '0);
   endfunction

   assign issue_go = issue_valid && !stall && !flush;

   // NOTE: the tracking array is a handful of flops, not a RAM, so every entry
   // is cleared by reset; <= keeps the shift ordering independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= NSTAGES; k++) stage[k] <= '0;
      end else begin
         if (issue_go)
            stage[1] <= '{valid: 1'b1, wr: issue_wr, regwrite: issue_regwrite,
                          memread: issue_memread};
         else
            stage[1] <= '0;
         for (int k = 2; k <= NSTAGES; k++) stage[k] <= stage[k-1];
      end
   end

   // NOTE: every comb output gets a default first so no path infers a latch;
   // scanning oldest to youngest lets the youngest match overwrite older ones.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      load_a = 1'b0;
      load_b = 1'b0;
      for (int k = NSTAGES; k >= 1; k--) begin
         if (match(stage[k], issue_rs)) begin
            sel_a  = SW'(k);
            load_a = stage[k].memread && (k < LOAD_READY);
         end
         if (match(stage[k], issue_rt)) begin
            sel_b  = SW'(k);
            load_b = stage[k].memread && (k < LOAD_READY);
         end
      end
   end

   assign stall     = issue_valid && !flush && (load_a || load_b);
   assign fwd_sel_a = (issue_valid && !stall) ? sel_a : '0;
   assign fwd_sel_b = (issue_valid && !stall) ? sel_b : '0;

   always_comb begin
      pending_writes = '0;
      for (int k = 1; k <= NSTAGES; k++)
         pending_writes = pending_writes + 4'(stage[k].valid && stage[k].regwrite);
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a 2-stage instance driven from a vector
// table plus hand sequences, and a 4-stage instance for the longer load-use window.
module tb_hazard_forward_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 2-stage instance, LOAD_READY=2
   logic       v2, rw2, mr2, fl2;
   logic [4:0] rs2, rt2, wr2;
   logic       stall2;
   logic [1:0] a2, b2;
   logic [3:0] pend2;

   // 4-stage instance, LOAD_READY=3
   logic       v4, rw4, mr4, fl4;
   logic [4:0] rs4, rt4, wr4;
   logic       stall4;
   logic [2:0] a4, b4;
   logic [3:0] pend4;

   hazard_forward_unit #(.NSTAGES(2), .LOAD_READY(2), .REG_W(5)) dut2 (
      .clk(clk), .reset(reset), .issue_valid(v2), .issue_rs(rs2), .issue_rt(rt2),
      .issue_wr(wr2), .issue_regwrite(rw2), .issue_memread(mr2), .flush(fl2),
      .stall(stall2), .fwd_sel_a(a2), .fwd_sel_b(b2), .pending_writes(pend2));

   hazard_forward_unit #(.NSTAGES(4), .LOAD_READY(3), .REG_W(5)) dut4 (
      .clk(clk), .reset(reset), .issue_valid(v4), .issue_rs(rs4), .issue_rt(rt4),
      .issue_wr(wr4), .issue_regwrite(rw4), .issue_memread(mr4), .flush(fl4),
      .stall(stall4), .fwd_sel_a(a4), .fwd_sel_b(b4), .pending_writes(pend4));

   typedef struct {
      logic       valid;
      logic [4:0] rs, rt, wr;
      logic       rw, mr, fl;
      logic       chk_sel;
      logic       e_stall;
      logic [1:0] e_a, e_b;
      logic [3:0] e_pend;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive2(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic rw, input logic mr, input logic fl);
      v2 = v; rs2 = rs; rt2 = rt; wr2 = wr; rw2 = rw; mr2 = mr; fl2 = fl;
   endtask

   task automatic drive4(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic rw, input logic mr);
      v4 = v; rs4 = rs; rt4 = rt; wr4 = wr; rw4 = rw; mr4 = mr; fl4 = 1'b0;
   endtask

   task automatic check4(input string tag, input logic e_stall, input logic [2:0] e_a,
                         input logic [2:0] e_b, input logic [3:0] e_pend);
      check({tag, " stall"}, 32'(stall4), 32'(e_stall));
      check({tag, " sel_a"}, 32'(a4), 32'(e_a));
      check({tag, " sel_b"}, 32'(b4), 32'(e_b));
      check({tag, " pend"},  32'(pend4), 32'(e_pend));
   endtask

   initial begin
      //          valid rs  rt  wr  rw mr fl chk stall a  b  pend
      vecs[0]  = '{1, 1,  2,  3,  1, 0, 0, 1, 0, 0, 0, 0};  // ALU write r3
      vecs[1]  = '{1, 3,  9,  10, 1, 0, 0, 1, 0, 1, 0, 1};  // rs=3 from stage 1
      vecs[2]  = '{1, 8,  3,  0,  0, 0, 0, 1, 0, 0, 2, 2};  // rt=3 from stage 2
      vecs[3]  = '{1, 0,  0,  5,  1, 0, 0, 1, 0, 0, 0, 1};  // write r5
      vecs[4]  = '{1, 1,  2,  5,  1, 0, 0, 1, 0, 0, 0, 1};  // write r5 again
      vecs[5]  = '{1, 5,  5,  6,  0, 0, 0, 1, 0, 1, 1, 2};  // youngest wins
      vecs[6]  = '{1, 0,  0,  4,  1, 1, 0, 1, 0, 0, 0, 1};  // lw r4
      vecs[7]  = '{1, 4,  1,  11, 1, 0, 0, 1, 1, 0, 0, 1};  // load-use stall
      vecs[8]  = '{1, 4,  1,  11, 1, 0, 0, 1, 0, 2, 0, 1};  // replay, forward stage 2
      vecs[9]  = '{1, 0,  11, 0,  1, 0, 0, 1, 0, 0, 1, 1};  // write r0 issued
      vecs[10] = '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 2};  // r0 entry never matches
      vecs[11] = '{1, 0,  0,  4,  1, 1, 0, 1, 0, 0, 0, 1};  // lw r4
      vecs[12] = '{1, 4,  0,  12, 1, 0, 1, 0, 0, 0, 0, 1};  // flush suppresses stall
      vecs[13] = '{1, 4,  0,  0,  0, 0, 0, 1, 0, 2, 0, 1};  // flushed slot was a bubble
      vecs[14] = '{0, 4,  4,  0,  0, 0, 0, 1, 0, 0, 0, 0};  // no issue -> quiet

      reset = 1'b1;
      drive2(0, 0, 0, 0, 0, 0, 0);
      drive4(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("reset stall", 32'(stall2), 32'd0);
      check("reset pend",  32'(pend2),  32'd0);
      reset = 1'b0;

      // Asynchronous reset in the middle of a cycle with two writes in flight
      drive2(1, 0, 0, 3, 1, 0, 0);
      @(negedge clk);
      drive2(1, 0, 0, 5, 1, 0, 0);
      @(negedge clk);
      drive2(1, 3, 5, 0, 0, 0, 0);
      #2;
      check("T1 pend before", 32'(pend2), 32'd2);
      check("T1 sel_a before", 32'(a2), 32'd2);
      check("T1 sel_b before", 32'(b2), 32'd1);
      reset = 1'b1;
      #1;
      check("T1 stall", 32'(stall2), 32'd0);
      check("T1 sel_a", 32'(a2), 32'd0);
      check("T1 sel_b", 32'(b2), 32'd0);
      check("T1 pend",  32'(pend2), 32'd0);
      drive2(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive2(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].wr,
                vecs[i].rw, vecs[i].mr, vecs[i].fl);
         #2;
         check($sformatf("v%0d stall", i), 32'(stall2), 32'(vecs[i].e_stall));
         check($sformatf("v%0d pend", i),  32'(pend2),  32'(vecs[i].e_pend));
         if (vecs[i].chk_sel) begin
            check($sformatf("v%0d sel_a", i), 32'(a2), 32'(vecs[i].e_a));
            check($sformatf("v%0d sel_b", i), 32'(b2), 32'(vecs[i].e_b));
         end
         @(negedge clk);
      end
      drive2(0, 0, 0, 0, 0, 0, 0);

      // Four-stage pipeline: load ready from stage 3, stage 4 still forwards
      drive4(1, 0, 0, 7, 1, 1);
      #2; check4("T6 c0", 0, 0, 0, 0);
      @(negedge clk);
      drive4(1, 7, 0, 9, 0, 0);
      #2; check4("T6 c1", 1, 0, 0, 1);
      @(negedge clk);
      #2; check4("T6 c2", 1, 0, 0, 1);
      @(negedge clk);
      #2; check4("T6 c3", 0, 3, 0, 1);
      @(negedge clk);
      drive4(1, 0, 7, 0, 0, 0);
      #2; check4("T6 c4", 0, 0, 4, 1);
      @(negedge clk);
      #2; check4("T6 c5", 0, 0, 0, 0);
      drive4(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
